pl_exmem: RTL and testbench
===========================

PL_EXMEM -- requirements
Module: pl_exmem

Interface
REQ-001 SHALL have parameter REG_AW, default 3, meaning register-file address width; data width is fixed at 8.
REQ-002 SHALL have ports, in this order:
  clk  in  1  stage clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  ex_valid  in  1  EX holds a real instruction
  alu_dout  in  8  ALU result
  alu_cout  in  1  ALU carry out
  comp_gt/comp_lt/comp_eq  in  1 each  ALU compare outputs
  add_op, compare_true, jump_true  in  1 each  decoded controls
  jump_cond  in  2  branch condition: 00 always, 01 eq, 10 gt, 11 lt
  addr_hi_ld  in  1  latch alu_dout as high data-address byte
  ex_rd  in  REG_AW  destination register
  ex_reg_we, ex_mem_rd, ex_mem_wr  in  1 each  writeback / load / store
  ex_store_data  in  8  store operand
  flush  in  1  squash EX instruction
  mem_ack  in  1  data memory completes the access
  mem_valid  out  1  MEM register holds a real instruction
  mem_result  out  8  registered ALU result
  mem_addr  out  16  data address {addr_hi, result}
  mem_wdata  out  8  store data
  mem_req  out  1  memory request, level
  mem_we  out  1  store qualifier for mem_req
  mem_rd  out  REG_AW  destination register
  mem_reg_we  out  1  writeback enable
  flag_c/flag_gt/flag_lt/flag_eq  out  1 each  status flags
  branch_taken  out  1  one-cycle taken-branch pulse
  ex_stall  out  1  freeze upstream stages

Function
REQ-003 SHALL implement a two-state FSM: IDLE and ACCESS.
REQ-004 In IDLE, the MEM register SHALL load all EX fields on every rising clk edge; mem_valid SHALL equal ex_valid & ~flush.
REQ-005 A flushed or invalid capture SHALL force mem_reg_we=0, mem_req=0 and branch_taken=0; data fields are don't-care.
REQ-006 A valid capture with ex_mem_rd|ex_mem_wr SHALL set mem_req=1, set mem_we=ex_mem_wr, and move the FSM to ACCESS in the same edge.
REQ-007 In ACCESS, the MEM register, flags and addr_hi SHALL hold; ex_stall SHALL be 1 combinationally.
REQ-008 In ACCESS, mem_ack=1 SHALL return the FSM to IDLE and drop mem_req on that edge.
REQ-009 In ACCESS, flush SHALL be ignored; upstream is stalled and holds the flushed instruction.
REQ-010 mem_ack SHALL be ignored in IDLE.
REQ-011 ex_stall SHALL be 0 in IDLE: load latency is exactly 1 cycle plus the mem_ack wait.
REQ-012 addr_hi SHALL load alu_dout on a valid, unflushed, IDLE capture with addr_hi_ld=1; that capture SHALL force mem_reg_we=0.
REQ-013 mem_addr SHALL be {addr_hi, mem_result} (combinational from registers); addr_hi persists until reloaded.
REQ-014 flag_c SHALL load alu_cout on a valid, unflushed, IDLE capture with add_op=1.
REQ-015 flag_gt/lt/eq SHALL load comp_gt/lt/eq on a valid, unflushed, IDLE capture with compare_true=1.
REQ-016 When REQ-014 and REQ-015 apply in the same capture, both updates SHALL occur.
REQ-017 Branch resolution SHALL use the flag values before the current edge.
REQ-018 branch_taken SHALL be 1 for exactly one cycle after a valid, unflushed, IDLE capture with jump_true=1 and the condition met.
REQ-019 A branch_taken pulse SHALL never coincide with a second pulse: a stall does not re-fire it.

Reset
REQ-020 rst_n low SHALL asynchronously set: FSM to IDLE; mem_valid, mem_req, mem_we, mem_reg_we, branch_taken, all flags to 0; mem_result, addr_hi, mem_wdata, mem_rd to 0.
REQ-021 Reset asserted during ACCESS SHALL abandon the access, with no retry.
REQ-022 Sequential state SHALL first update on the first rising clk edge after rst_n deasserts.

Structure
REQ-023 A shared package SHALL hold the FSM state encoding (IDLE=0, ACCESS=1) and the jump_cond codes.
REQ-024 One sub-module, pl_flagreg, SHALL hold the flags and evaluate branch conditions; all other logic stays in pl_exmem.

Verification
REQ-025 Reset: rst_n low mid-cycle -> all outputs 0 immediately, before any clk edge.
REQ-026 ALU op: alu_dout=8'h5A, ex_rd=3, ex_reg_we=1, valid -> next cycle mem_result=5A, mem_rd=3, mem_reg_we=1, ex_stall=0.
REQ-027 Load with a 2-cycle wait: addr_hi_ld with 8'h12, then a load with alu_dout=8'h34 -> mem_addr=16'h1234, mem_req=1; ex_stall=1 until mem_ack on cycle 3; then FSM returns to IDLE with mem_req=0.
REQ-028 Compare then branch: compare with gt=1, then jump_cond=10, jump_true=1 -> branch_taken pulses for exactly 1 cycle; same sequence with jump_cond=01 -> no pulse.
REQ-029 Flush: flush=1 on a valid store -> mem_valid=0, mem_req=0, flags unchanged; flush=1 during ACCESS -> no effect.
REQ-030 Wrap/hold: addr_hi=8'hFF, result=8'hFF -> mem_addr=16'hFFFF; a later ALU op without addr_hi_ld leaves addr_hi=FF.

Source files
------------

// File: rtl/pl_exmem_pkg.sv
// pl_exmem_pkg: shared FSM state encoding, branch-condition codes and condition helper
package pl_exmem_pkg;

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_e;

    typedef enum logic [1:0] {
        JC_ALWAYS = 2'b00,
        JC_EQ     = 2'b01,
        JC_GT     = 2'b10,
        JC_LT     = 2'b11
    } jcond_e;

    function automatic logic cond_met(input logic [1:0] jc, input logic eq, input logic gt, input logic lt);
        return jc == JC_ALWAYS ? 1'b1 : jc == JC_EQ ? eq : jc == JC_GT ? gt : lt;
    endfunction

endpackage

// File: rtl/pl_exmem_flagreg.sv
// pl_flagreg: status flags and branch resolution against the flags held before the edge
module pl_flagreg
    import pl_exmem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cap,
    input  logic       add_op,
    input  logic       compare_true,
    input  logic       jump_true,
    input  logic [1:0] jump_cond,
    input  logic       alu_cout,
    input  logic       comp_gt,
    input  logic       comp_lt,
    input  logic       comp_eq,
    output logic       flag_c,
    output logic       flag_gt,
    output logic       flag_lt,
    output logic       flag_eq,
    output logic       branch_taken
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_c       <= 1'b0;
            flag_gt      <= 1'b0;
            flag_lt      <= 1'b0;
            flag_eq      <= 1'b0;
            branch_taken <= 1'b0;
        end else begin
            if (cap && add_op)
                flag_c <= alu_cout;
            if (cap && compare_true) begin
                flag_gt <= comp_gt;
                flag_lt <= comp_lt;
                flag_eq <= comp_eq;
            end
            // cap is low while stalled, so a pulse can never repeat
            branch_taken <= cap & jump_true & cond_met(jump_cond, flag_eq, flag_gt, flag_lt);
        end
    end

endmodule

// File: rtl/pl_exmem.sv
// pl_exmem: EX/MEM pipeline register with data-memory handshake FSM and stall generation
module pl_exmem
    import pl_exmem_pkg::*;
#(
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [7:0]        alu_dout,
    input  logic              alu_cout,
    input  logic              comp_gt,
    input  logic              comp_lt,
    input  logic              comp_eq,
    input  logic              add_op,
    input  logic              compare_true,
    input  logic              jump_true,
    input  logic [1:0]        jump_cond,
    input  logic              addr_hi_ld,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_we,
    input  logic              ex_mem_rd,
    input  logic              ex_mem_wr,
    input  logic [7:0]        ex_store_data,
    input  logic              flush,
    input  logic              mem_ack,
    output logic              mem_valid,
    output logic [7:0]        mem_result,
    output logic [15:0]       mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [REG_AW-1:0] mem_rd,
    output logic              mem_reg_we,
    output logic              flag_c,
    output logic              flag_gt,
    output logic              flag_lt,
    output logic              flag_eq,
    output logic              branch_taken,
    output logic              ex_stall
);

    state_e     state, state_d;
    logic [7:0] addr_hi;
    logic       idle, cap, acc;

    assign idle     = state == IDLE;
    assign cap      = idle & ex_valid & ~flush;
    assign acc      = ex_mem_rd | ex_mem_wr;
    assign ex_stall = ~idle;
    assign mem_addr = {addr_hi, mem_result};

    always_comb begin
        state_d = state;
        state_d = idle ? (cap && acc ? ACCESS : IDLE) : (mem_ack ? IDLE : ACCESS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mem_valid  <= 1'b0;
            mem_result <= '0;
            mem_wdata  <= '0;
            mem_rd     <= '0;
            mem_reg_we <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            addr_hi    <= '0;
        end else begin
            state <= state_d;
            if (idle) begin
                mem_valid  <= cap;
                mem_result <= alu_dout;
                mem_wdata  <= ex_store_data;
                mem_rd     <= ex_rd;
                mem_reg_we <= cap & ex_reg_we & ~addr_hi_ld;
                mem_req    <= cap & acc;
                mem_we     <= cap & ex_mem_wr;
                if (cap && addr_hi_ld)
                    addr_hi <= alu_dout;
            end else if (mem_ack) begin
                mem_req <= 1'b0;
            end
        end
    end

    pl_flagreg u_flagreg (
        .clk          (clk),
        .rst_n        (rst_n),
        .cap          (cap),
        .add_op       (add_op),
        .compare_true (compare_true),
        .jump_true    (jump_true),
        .jump_cond    (jump_cond),
        .alu_cout     (alu_cout),
        .comp_gt      (comp_gt),
        .comp_lt      (comp_lt),
        .comp_eq      (comp_eq),
        .flag_c       (flag_c),
        .flag_gt      (flag_gt),
        .flag_lt      (flag_lt),
        .flag_eq      (flag_eq),
        .branch_taken (branch_taken)
    );

endmodule

// File: tb/tb_pl_exmem.sv
// tb_pl_exmem: directed scenarios plus randomized traffic checked against a cycle-level behavioural model
module tb_pl_exmem;

    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          ex_valid, alu_cout, comp_gt, comp_lt, comp_eq;
    logic          add_op, compare_true, jump_true, addr_hi_ld;
    logic [1:0]    jump_cond;
    logic [7:0]    alu_dout, ex_store_data;
    logic [AW-1:0] ex_rd;
    logic          ex_reg_we, ex_mem_rd, ex_mem_wr, flush, mem_ack;
    logic          mem_valid, mem_req, mem_we, mem_reg_we;
    logic [7:0]    mem_result, mem_wdata;
    logic [15:0]   mem_addr;
    logic [AW-1:0] mem_rd;
    logic          flag_c, flag_gt, flag_lt, flag_eq, branch_taken, ex_stall;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pl_exmem #(.REG_AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .alu_dout(alu_dout), .alu_cout(alu_cout),
        .comp_gt(comp_gt), .comp_lt(comp_lt), .comp_eq(comp_eq), .add_op(add_op),
        .compare_true(compare_true), .jump_true(jump_true), .jump_cond(jump_cond),
        .addr_hi_ld(addr_hi_ld), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .ex_mem_rd(ex_mem_rd),
        .ex_mem_wr(ex_mem_wr), .ex_store_data(ex_store_data), .flush(flush), .mem_ack(mem_ack),
        .mem_valid(mem_valid), .mem_result(mem_result), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_rd(mem_rd), .mem_reg_we(mem_reg_we),
        .flag_c(flag_c), .flag_gt(flag_gt), .flag_lt(flag_lt), .flag_eq(flag_eq),
        .branch_taken(branch_taken), .ex_stall(ex_stall)
    );

    // Reference model: one outstanding memory access at most; while it waits, nothing moves.
    logic          m_busy, m_valid, m_rwe, m_req, m_we, m_c, m_gt, m_lt, m_eq, m_bt;
    logic [7:0]    m_result, m_hi, m_wdata;
    logic [AW-1:0] m_rd;
    wire           take = ex_valid && !flush;
    wire           cond = jump_cond == 2'd0 ? 1'b1 : jump_cond == 2'd1 ? m_eq : jump_cond == 2'd2 ? m_gt : m_lt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {m_busy, m_valid, m_rwe, m_req, m_we, m_c, m_gt, m_lt, m_eq, m_bt} <= '0;
            {m_result, m_hi, m_wdata, m_rd} <= '0;
        end else if (!m_busy) begin
            m_valid  <= take;
            m_result <= alu_dout;
            m_wdata  <= ex_store_data;
            m_rd     <= ex_rd;
            m_rwe    <= take && ex_reg_we && !addr_hi_ld;
            m_req    <= take && (ex_mem_rd || ex_mem_wr);
            m_we     <= take && ex_mem_wr;
            m_busy   <= take && (ex_mem_rd || ex_mem_wr);
            if (take && addr_hi_ld) m_hi <= alu_dout;
            if (take && add_op) m_c <= alu_cout;
            if (take && compare_true) {m_gt, m_lt, m_eq} <= {comp_gt, comp_lt, comp_eq};
            m_bt <= take && jump_true && cond;
        end else begin
            m_bt <= 1'b0;
            if (mem_ack) begin
                m_busy <= 1'b0;
                m_req  <= 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clr();
        {ex_valid, alu_cout, comp_gt, comp_lt, comp_eq, add_op, compare_true, jump_true, addr_hi_ld} = '0;
        {ex_reg_we, ex_mem_rd, ex_mem_wr, flush, mem_ack} = '0;
        jump_cond = 2'd0;
        alu_dout = 8'h00;
        ex_store_data = 8'h00;
        ex_rd = '0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"}, {mem_valid, mem_req, mem_we, mem_reg_we, flag_c, flag_gt, flag_lt, flag_eq,
                                branch_taken, ex_stall}, 16'h0);
        check({tag, "_addr"}, mem_addr, 16'h0);
        check({tag, "_data"}, {mem_result, mem_wdata}, 16'h0);
        check({tag, "_rd"}, {13'h0, mem_rd}, 16'h0);
    endtask

    task automatic check_model();
        check("r_valid", {15'h0, mem_valid}, {15'h0, m_valid});
        check("r_req", {15'h0, mem_req}, {15'h0, m_req});
        check("r_stall", {15'h0, ex_stall}, {15'h0, m_busy});
        check("r_rwe", {15'h0, mem_reg_we}, {15'h0, m_rwe});
        check("r_flags", {12'h0, flag_c, flag_gt, flag_lt, flag_eq}, {12'h0, m_c, m_gt, m_lt, m_eq});
        check("r_bt", {15'h0, branch_taken}, {15'h0, m_bt});
        if (m_req) check("r_we", {15'h0, mem_we}, {15'h0, m_we});
        if (m_valid) begin
            check("r_addr", mem_addr, {m_hi, m_result});
            check("r_wdata", {8'h0, mem_wdata}, {8'h0, m_wdata});
            check("r_rd", {13'h0, mem_rd}, {13'h0, m_rd});
        end
    endtask

    initial begin
        clr();
        alu_dout = 8'hA5;
        ex_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset_async");
        step();
        step();
        clr();
        rst_n = 1'b1;
        step();
        check_all_zero("reset_idle");

        // ALU op writeback
        ex_valid = 1'b1; alu_dout = 8'h5A; ex_rd = 3'd3; ex_reg_we = 1'b1;
        step();
        check("alu_result", {8'h0, mem_result}, 16'h005A);
        check("alu_rd", {13'h0, mem_rd}, 16'd3);
        check("alu_rwe", {15'h0, mem_reg_we}, 16'd1);
        check("alu_stall", {15'h0, ex_stall}, 16'd0);

        // High address byte, then a load that waits two cycles
        clr(); ex_valid = 1'b1; alu_dout = 8'h12; addr_hi_ld = 1'b1; ex_reg_we = 1'b1;
        step();
        check("hi_rwe", {15'h0, mem_reg_we}, 16'd0);
        clr(); ex_valid = 1'b1; alu_dout = 8'h34; ex_mem_rd = 1'b1; ex_reg_we = 1'b1;
        step();
        check("ld_addr", mem_addr, 16'h1234);
        check("ld_req", {14'h0, mem_req, mem_we}, 16'b10);
        check("ld_stall1", {15'h0, ex_stall}, 16'd1);
        clr(); mem_ack = 1'b0;
        step();
        check("ld_stall2", {14'h0, ex_stall, mem_req}, 16'b11);
        mem_ack = 1'b1;
        step();
        check("ld_done", {14'h0, ex_stall, mem_req}, 16'b00);
        check("ld_hold", mem_addr, 16'h1234);

        // Compare then branch on gt (taken) and on eq (not taken)
        clr(); ex_valid = 1'b1; compare_true = 1'b1; comp_gt = 1'b1;
        step();
        check("cmp_flags", {13'h0, flag_gt, flag_lt, flag_eq}, 16'b100);
        clr(); ex_valid = 1'b1; jump_true = 1'b1; jump_cond = 2'b10;
        step();
        check("br_gt_pulse", {15'h0, branch_taken}, 16'd1);
        clr();
        step();
        check("br_gt_end", {15'h0, branch_taken}, 16'd0);
        ex_valid = 1'b1; jump_true = 1'b1; jump_cond = 2'b01;
        step();
        check("br_eq_none", {15'h0, branch_taken}, 16'd0);

        // Flushed store does nothing; flush during an access is ignored
        clr(); ex_valid = 1'b1; ex_mem_wr = 1'b1; flush = 1'b1;
        add_op = 1'b1; alu_cout = 1'b1; compare_true = 1'b1; comp_eq = 1'b1;
        step();
        check("fl_store", {13'h0, mem_valid, mem_req, ex_stall}, 16'b000);
        check("fl_flags", {12'h0, flag_c, flag_gt, flag_lt, flag_eq}, 16'b0100);
        clr(); ex_valid = 1'b1; ex_mem_wr = 1'b1; alu_dout = 8'h77; ex_store_data = 8'hC3;
        step();
        check("st_req", {14'h0, mem_req, mem_we}, 16'b11);
        check("st_wdata", {8'h0, mem_wdata}, 16'h00C3);
        clr(); ex_valid = 1'b1; flush = 1'b1; alu_dout = 8'h11;
        step();
        check("fl_acc", {13'h0, mem_valid, mem_req, ex_stall}, 16'b111);
        check("fl_acc_res", {8'h0, mem_result}, 16'h0077);
        clr(); mem_ack = 1'b1;
        step();
        check("st_done", {14'h0, mem_req, ex_stall}, 16'b00);

        // Address wrap and addr_hi persistence
        clr(); ex_valid = 1'b1; alu_dout = 8'hFF; addr_hi_ld = 1'b1;
        step();
        clr(); ex_valid = 1'b1; alu_dout = 8'hFF; ex_reg_we = 1'b1;
        step();
        check("wrap", mem_addr, 16'hFFFF);
        alu_dout = 8'h01;
        step();
        check("hi_persist", mem_addr, 16'hFF01);

        // Reset in the middle of an access abandons it
        clr(); ex_valid = 1'b1; ex_mem_rd = 1'b1;
        step();
        check("rs_req", {14'h0, mem_req, ex_stall}, 16'b11);
        clr();
        #2 rst_n = 1'b0;
        #1 check_all_zero("rs_acc");
        step();
        rst_n = 1'b1;
        step();
        check("rs_noretry", {14'h0, mem_req, ex_stall}, 16'b00);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            ex_valid      = $urandom_range(0, 9) < 8;
            alu_dout      = 8'($urandom);
            alu_cout      = 1'($urandom);
            {comp_gt, comp_lt, comp_eq} = 3'($urandom);
            add_op        = 1'($urandom);
            compare_true  = 1'($urandom);
            jump_true     = $urandom_range(0, 2) == 0;
            jump_cond     = 2'($urandom);
            addr_hi_ld    = $urandom_range(0, 6) == 0;
            ex_rd         = AW'($urandom);
            ex_reg_we     = 1'($urandom);
            ex_mem_rd     = $urandom_range(0, 4) == 0;
            ex_mem_wr     = $urandom_range(0, 4) == 0;
            ex_store_data = 8'($urandom);
            flush         = $urandom_range(0, 9) == 0;
            mem_ack       = $urandom_range(0, 2) == 0;
            step();
            check_model();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
